// File: rtl/grid_render_pkg.sv
// grid_render_pkg: geometry defaults, colour constants and shared types for the grid renderer.
package grid_render_pkg;
    localparam int DEF_GRID_COLS = 10;
    localparam int DEF_GRID_ROWS = 20;
    localparam int DEF_TILE_PX   = 8;
    localparam int DEF_TILE_ID_W = 4;
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_X_OFFSET  = 240;
    localparam int DEF_Y_OFFSET  = 80;
    localparam int DEF_RGB_W     = 8;

    localparam logic [7:0] DEF_BG_RGB    = 8'h00;
    localparam logic [7:0] DEF_EMPTY_RGB = 8'h25;
    localparam logic [7:0] DEF_LINE_RGB  = 8'h49;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [31:0] coord_t;

    typedef struct packed {
        logic in_field;
        logic line;
        logic lines_en;
    } px_flags_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: active-area x/y position, advanced by the pixel strobe and reloaded at frame start.
module raster_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          px_en_i,
    input  logic          frame_start_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o
);
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          x_last, y_last;

    assign x_last = x_q == XW'(H_ACTIVE - 1);
    assign y_last = y_q == YW'(V_ACTIVE - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (frame_start_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (px_en_i) begin
            x_q <= x_last ? '0 : x_q + 1'b1;
            if (x_last) y_q <= y_last ? '0 : y_q + 1'b1;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: three-stage playfield renderer (cell fetch, texel fetch, colour select)
// advancing on the pixel strobe, flushed by frame_start.
module grid_renderer
    import grid_render_pkg::*;
#(
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int TILE_PX   = DEF_TILE_PX,
    parameter int TILE_ID_W = DEF_TILE_ID_W,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int X_OFFSET  = DEF_X_OFFSET,
    parameter int Y_OFFSET  = DEF_Y_OFFSET,
    parameter int RGB_W     = DEF_RGB_W,
    parameter logic [RGB_W-1:0] BG_RGB    = RGB_W'(DEF_BG_RGB),
    parameter logic [RGB_W-1:0] EMPTY_RGB = RGB_W'(DEF_EMPTY_RGB),
    parameter logic [RGB_W-1:0] LINE_RGB  = RGB_W'(DEF_LINE_RGB),
    localparam int GA_W = cw(GRID_COLS * GRID_ROWS),
    localparam int TW   = $clog2(TILE_PX),
    localparam int TA_W = TILE_ID_W + 2 * TW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             px_en_i,
    input  logic             frame_start_i,
    input  logic             lines_en_i,
    input  logic [7:0]       grid_data_i,
    input  logic [RGB_W-1:0] tile_data_i,
    output logic [GA_W-1:0]  grid_addr_o,
    output logic [TA_W-1:0]  tile_addr_o,
    output logic [RGB_W-1:0] pixel_rgb_o,
    output logic             pixel_valid_o
);
    localparam int     XW   = cw(H_ACTIVE);
    localparam int     YW   = cw(V_ACTIVE);
    localparam coord_t X_LO = coord_t'(X_OFFSET);
    localparam coord_t X_HI = coord_t'(X_OFFSET + GRID_COLS * TILE_PX);
    localparam coord_t Y_LO = coord_t'(Y_OFFSET);
    localparam coord_t Y_HI = coord_t'(Y_OFFSET + GRID_ROWS * TILE_PX);

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    coord_t               dx, dy;
    logic                 in_field;
    logic [GA_W-1:0]      addr_d;
    logic [RGB_W-1:0]     rgb_d;
    logic [GA_W-1:0]      grid_addr_q;
    logic [TW-1:0]        sub_x_q, sub_y_q;
    px_flags_t            f0_q, f1_q;
    logic                 v0_q, v1_q;
    logic [TA_W-1:0]      tile_addr_q;
    logic [TILE_ID_W-1:0] id1_q;
    logic [RGB_W-1:0]     pixel_rgb_q;
    logic                 pixel_valid_q;
    logic                 unused_hi;

    raster_counter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .XW      (XW),
        .YW      (YW)
    ) u_raster (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .px_en_i      (px_en_i),
        .frame_start_i(frame_start_i),
        .x_o          (x),
        .y_o          (y)
    );

    // Offsets wrap when left of / above the field; only consumed once in_field holds.
    assign dx       = coord_t'(x) - X_LO;
    assign dy       = coord_t'(y) - Y_LO;
    assign in_field = coord_t'(x) >= X_LO && coord_t'(x) < X_HI &&
                      coord_t'(y) >= Y_LO && coord_t'(y) < Y_HI;
    assign addr_d   = GA_W'((dy >> TW) * GRID_COLS + (dx >> TW));

    assign rgb_d = !f1_q.in_field                 ? BG_RGB    :
                   (f1_q.lines_en && f1_q.line)  ? LINE_RGB  :
                   (id1_q == '0)                 ? EMPTY_RGB : tile_data_i;

    assign unused_hi = ^(grid_data_i >> TILE_ID_W);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grid_addr_q   <= '0;
            sub_x_q       <= '0;
            sub_y_q       <= '0;
            f0_q          <= '0;
            v0_q          <= 1'b0;
            tile_addr_q   <= '0;
            id1_q         <= '0;
            f1_q          <= '0;
            v1_q          <= 1'b0;
            pixel_rgb_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else if (frame_start_i) begin
            v0_q          <= 1'b0;
            v1_q          <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_valid_q <= px_en_i && v1_q;
            if (px_en_i) begin
                if (in_field) grid_addr_q <= addr_d;
                sub_x_q     <= dx[TW-1:0];
                sub_y_q     <= dy[TW-1:0];
                f0_q        <= '{in_field, dx[TW-1:0] == '0 || dy[TW-1:0] == '0, lines_en_i};
                v0_q        <= 1'b1;
                tile_addr_q <= {grid_data_i[TILE_ID_W-1:0], sub_y_q, sub_x_q};
                id1_q       <= grid_data_i[TILE_ID_W-1:0];
                f1_q        <= f0_q;
                v1_q        <= v0_q;
                if (v1_q) pixel_rgb_q <= rgb_d;
            end
        end
    end

    assign grid_addr_o   = grid_addr_q;
    assign tile_addr_o   = tile_addr_q;
    assign pixel_rgb_o   = pixel_rgb_q;
    assign pixel_valid_o = pixel_valid_q;
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: randomized scoreboard bench for grid_renderer on a reduced geometry.
module tb_grid_renderer;
    localparam int C = 5, R = 4, T = 4, IDW = 4, HA = 40, VA = 30, XO = 12, YO = 6;
    localparam logic [7:0] BG = 8'h0B, EMPTY = 8'h25, LINE = 8'h49;

    logic       clk = 0, rst_n = 0, px_en = 0, frame_start = 0, lines_en = 0;
    logic [7:0] grid_data, tile_data, pixel_rgb;
    logic [4:0] grid_addr;
    logic [7:0] tile_addr;
    logic       pixel_valid;
    logic [7:0] gmem [32];
    logic [7:0] tmem [256];
    logic [7:0] exp_q [$];
    int n_cmp = 0, n_bad = 0, nvalid = 0;
    int mx = 0, my = 0, since = 0, last_addr = 0, prev_ta = 0;
    bit prev_in = 0;

    always #5 clk = ~clk;

    assign grid_data = gmem[grid_addr];
    assign tile_data = tmem[tile_addr];

    grid_renderer #(
        .GRID_COLS(C), .GRID_ROWS(R), .TILE_PX(T), .TILE_ID_W(IDW),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .X_OFFSET(XO), .Y_OFFSET(YO), .RGB_W(8),
        .BG_RGB(BG), .EMPTY_RGB(EMPTY), .LINE_RGB(LINE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .px_en_i      (px_en),
        .frame_start_i(frame_start),
        .lines_en_i   (lines_en),
        .grid_data_i  (grid_data),
        .tile_data_i  (tile_data),
        .grid_addr_o  (grid_addr),
        .tile_addr_o  (tile_addr),
        .pixel_rgb_o  (pixel_rgb),
        .pixel_valid_o(pixel_valid)
    );

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every pixel_valid pulse must match the oldest outstanding expected pixel.
    always @(negedge clk) begin
        if (rst_n && pixel_valid) begin
            nvalid++;
            chk("valid_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("pixel_rgb", pixel_rgb, exp_q.pop_front());
        end
    end

    // One clock of stimulus; the reference model advances only on an accepted strobe.
    task automatic step(input bit fs, input bit pe, input bit le);
        bit in;
        int c, r, sx, sy, id, ta;
        logic [7:0] rgb;
        frame_start = fs;
        px_en = pe;
        lines_en = le;
        @(posedge clk);
        #1;
        frame_start = 0;
        px_en = 0;
        if (!rst_n) return;
        if (fs) begin
            mx = 0;
            my = 0;
            since = 0;
            exp_q.delete();
        end else if (pe) begin
            in = mx >= XO && mx < XO + C * T && my >= YO && my < YO + R * T;
            ta = 0;
            rgb = BG;
            if (in) begin
                c = (mx - XO) / T;
                r = (my - YO) / T;
                sx = (mx - XO) % T;
                sy = (my - YO) % T;
                id = gmem[r * C + c] % 16;
                last_addr = r * C + c;
                ta = (id * T + sy) * T + sx;
                rgb = (le && (sx == 0 || sy == 0)) ? LINE : (id == 0) ? EMPTY : tmem[ta];
            end
            exp_q.push_back(rgb);
            chk("grid_addr", grid_addr, last_addr);
            if (since > 0 && prev_in) chk("tile_addr", tile_addr, prev_ta);
            prev_in = in;
            prev_ta = ta;
            since++;
            mx++;
            if (mx == HA) begin
                mx = 0;
                my = (my == VA - 1) ? 0 : my + 1;
            end
        end
    endtask

    task automatic run(input int n, input int lemode, input int maxgap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(maxgap)) step(0, 0, 0);
            step(0, 1, lemode == 2 ? 1'($urandom_range(1)) : 1'(lemode));
        end
    endtask

    task automatic prime_check(input bit le);
        int n0;
        n0 = nvalid;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, le);
            @(negedge clk);
            #1;
            chk("prime_pulses", nvalid - n0, (i == 2) ? 1 : 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grid_addr"}, grid_addr, 0);
        chk({tag, "_tile_addr"}, tile_addr, 0);
        chk({tag, "_pixel_rgb"}, pixel_rgb, 0);
        chk({tag, "_pixel_valid"}, pixel_valid, 0);
    endtask

    // Asynchronous reset mid-line: outputs must clear before the next clock edge.
    task automatic do_reset();
        #2 rst_n = 0;
        #1 chk_zero("async_rst");
        step(0, 1, 0);
        step(0, 1, 0);
        rst_n = 1;
        mx = 0;
        my = 0;
        since = 0;
        last_addr = 0;
        prev_in = 0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        for (int i = 0; i < 32; i++) begin
            gmem[i] = 8'($urandom);
            if ($urandom_range(3) == 0) gmem[i] = gmem[i] & 8'hF0;
        end
        for (int i = 0; i < 256; i++) tmem[i] = 8'($urandom);
        gmem[0] = 8'hF3;
        gmem[19] = 8'hA0;
        tmem[8'h30] = 8'hE0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        step(1, 0, 0);
        n0 = nvalid;
        prime_check(0);
        run(HA * VA - 1, 0, 2);
        @(negedge clk);
        #1;
        chk("frame1_pulses", nvalid - n0, HA * VA);

        step(1, 0, 0);
        n0 = nvalid;
        run(HA * VA + 2, 1, 0);
        @(negedge clk);
        #1;
        chk("frame2_pulses", nvalid - n0, HA * VA);

        step(1, 0, 0);
        run(500, 2, 1);
        step(1, 1, 0);
        prime_check(1);
        run(300, 2, 0);

        run(17, 2, 0);
        do_reset();
        prime_check(0);
        run(HA * VA + 100, 2, 1);
        @(negedge clk);
        #1;
        chk("pending_at_end", exp_q.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/grid_renderer.md
# grid_renderer

Parametrised playfield renderer: walks the active raster in step with the pixel strobe, fetches the cell byte from grid memory, fetches the matching tile texel from tile (VGA) memory, and emits one RGB value per active pixel. It sits between the VGA timing generator and the DAC/output register, replacing the fixed-geometry grid-to-video stage. It adds:
- configurable grid/tile/screen geometry
- playfield offset with background fill
- empty-cell colour
- optional grid-line overlay
- frame-synchronous pipeline flush

## Interface
- GRID_COLS, 10, playfield columns
- GRID_ROWS, 20, playfield rows
- TILE_PX, 8, tile edge in pixels; power of two, ≥2
- TILE_ID_W, 4, tile-id bits taken from grid_data[TILE_ID_W-1:0]
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- X_OFFSET, 240, playfield left edge (pixels)
- Y_OFFSET, 80, playfield top edge (lines)
- RGB_W, 8, pixel width
- BG_RGB, 8'h00, colour outside playfield
- EMPTY_RGB, 8'h25, colour of tile id 0
- LINE_RGB, 8'h49, grid-line colour
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- px_en  in  1  one-cycle strobe per active pixel, raster order
- frame_start  in  1  one-cycle pulse before first pixel of a frame
- lines_en  in  1  grid-line overlay enable, sampled per pixel
- grid_data  in  8  grid memory read data (1-cycle synchronous read)
- tile_data  in  RGB_W  tile memory read data (1-cycle synchronous read)
- grid_addr  out  clog2(GRID_COLS*GRID_ROWS)  grid memory address
- tile_addr  out  TILE_ID_W+2*log2(TILE_PX)  tile memory address
- pixel_rgb  out  RGB_W  rendered pixel
- pixel_valid  out  1  pixel_rgb holds a new pixel (one cycle per px_en, after latency)

## Operation
- Raster counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) advance on px_en.
  - x wraps to 0 and y increments.
  - At x=H_ACTIVE-1, y=V_ACTIVE-1 both wrap to 0.
- frame_start: x=y=0, all pipeline valid bits cleared. Has priority over a coincident px_en, which is dropped.
- Three pipeline stages, each advancing only on px_en:
  - S0: in_field = X_OFFSET≤x<X_OFFSET+GRID_COLS*TILE_PX and Y_OFFSET≤y<Y_OFFSET+GRID_ROWS*TILE_PX.
    - col=(x-X_OFFSET)>>log2(TILE_PX), row likewise.
    - grid_addr=row*GRID_COLS+col; sub_x/sub_y = low log2(TILE_PX) bits.
    - grid_addr is held unchanged when not in_field.
  - S1: tile_addr={grid_data[TILE_ID_W-1:0], sub_y, sub_x}; carry tile id, in_field, line flag (sub_x==0 or sub_y==0).
  - S2: pixel_rgb and pixel_valid=1 for one clk.
- S2 colour priority:
  - !in_field → BG_RGB
  - lines_en & line flag → LINE_RGB
  - tile id 0 → EMPTY_RGB
  - else tile_data
- grid_data bits above TILE_ID_W are ignored.
- Address arithmetic is unsigned; no out-of-range grid_addr is ever driven.

## Timing
- RAM reads: address registered at px_en edge; data valid next clk and held until the next address change. This requires px_en spacing ≥2 clk. px_en every clk is legal only with 1-cycle RAMs and is the worst case to verify.
- Latency: the pixel strobed at px_en edge n appears on pixel_valid on the clk after px_en strobe n+2. Exactly one pixel_valid per px_en once primed.
- After frame_start or reset, the first two px_en produce no pixel_valid.
- Reset values: grid_addr=0, tile_addr=0, pixel_rgb=0, pixel_valid=0, x=y=0, valids=0.
- Reset mid-frame aborts immediately. Rendering resumes only after the next frame_start; pixels strobed before it still render from x=y=0.

## Structure
- Package grid_render_pkg: clog2-derived widths, tile coordinate typedefs, default colour constants.
- One natural sub-module: raster_counter (x/y counters with wrap and frame_start load). Pipeline and colour mux stay in grid_renderer.

## Test plan
- Reset, frame_start, 3 px_en with defaults → pixel_valid first high after 3rd strobe, pixel_rgb=BG_RGB (pixel 0,0).
- Drive to x=240,y=80, grid cell 0 = 8'h03, tile_data 8'hE0, lines_en=0 → grid_addr=0, tile_addr={4'h3,3'd0,3'd0}, pixel_rgb=8'hE0.
- Same pixel with lines_en=1 → pixel_rgb=8'h49; x=241,y=81 → 8'hE0.
- Cell (col 9,row 19) id 0 at x=319,y=239 → grid_addr=199, pixel_rgb=8'h25; x=320 → 8'h00.
- Run a full frame: x wraps at 639, y at 479; exactly 307200 pixel_valid pulses. frame_start coincident with px_en mid-frame → strobe dropped, two-pixel bubble, restart at (0,0).
- Assert reset mid-line with px_en every clk → all outputs 0 asynchronously; no pixel_valid until 3rd px_en after release.
